// File: rtl/disp_arbiter.sv
// disp_arbiter
//   Shares one 8-digit display among three requesters. A requester that wins
//   arbitration keeps the display for at least HOLD_CYCLES clocks. After that
//   it keeps the display until another requester asks for it, or until it
//   drops its own request. Winners are chosen round-robin.
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   req[2:0]   level requests, bit i = requester i
//   data0..2   32-bit display words, one per requester
//   grant[2:0] registered one-hot ownership, 3'b000 when idle
//   owner[1:0] index of the current owner, 2'd3 when idle
//   disp_data  registered word sent to the display chain
//   locked     high while the minimum hold period is running
module disp_arbiter #(
    parameter logic [31:0] HOLD_CYCLES  = 32'd50_000_000,
    parameter logic [31:0] DEFAULT_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  req,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    output logic [2:0]  grant,
    output logic [1:0]  owner,
    output logic [31:0] disp_data,
    output logic        locked
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        OWN  = 2'd2
    } state_t;

    localparam logic [1:0] NO_OWNER = 2'd3;

    state_t      state_r, state_s;
    logic [31:0] cnt_r, cnt_s;
    logic [1:0]  last_owner_r, last_owner_s;
    logic [2:0]  grant_r, grant_s;
    logic [1:0]  owner_r, owner_s;
    logic [31:0] disp_data_r, disp_data_s;
    logic        locked_r, locked_s;
    logic [1:0]  idle_pick_s;
    logic [1:0]  preempt_pick_s;
    logic        take_s;
    logic [1:0]  take_idx_s;

    // Round-robin search that starts just after 'last' and wraps.
    // Returns NO_OWNER when no bit of 'r' is set.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] pick;
        pick = NO_OWNER;
        case (last)
            2'd0: begin
                if (r[1])      pick = 2'd1;
                else if (r[2]) pick = 2'd2;
                else if (r[0]) pick = 2'd0;
                else           pick = NO_OWNER;
            end
            2'd1: begin
                if (r[2])      pick = 2'd2;
                else if (r[0]) pick = 2'd0;
                else if (r[1]) pick = 2'd1;
                else           pick = NO_OWNER;
            end
            default: begin
                if (r[0])      pick = 2'd0;
                else if (r[1]) pick = 2'd1;
                else if (r[2]) pick = 2'd2;
                else           pick = NO_OWNER;
            end
        endcase
        return pick;
    endfunction

    // Index to one-hot grant vector; an out-of-range index means no grant.
    function automatic logic [2:0] to_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Word belonging to the requester at 'idx'; DEFAULT_DATA when nobody owns the display.
    function automatic logic [31:0] sel_data(input logic [1:0] idx, input logic [31:0] d0,
                                             input logic [31:0] d1, input logic [31:0] d2);
        logic [31:0] d;
        case (idx)
            2'd0:    d = d0;
            2'd1:    d = d1;
            2'd2:    d = d2;
            default: d = DEFAULT_DATA;
        endcase
        return d;
    endfunction

    // Candidate winners: any requester from IDLE, only non-owners from OWN.
    // In OWN the last owner is the current owner, so the search starts at owner+1.
    always_comb begin
        idle_pick_s    = rr_pick(req, last_owner_r);
        preempt_pick_s = rr_pick(req & ~grant_r, last_owner_r);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        last_owner_s = last_owner_r;
        grant_s      = grant_r;
        owner_s      = owner_r;
        disp_data_s  = disp_data_r;
        locked_s     = locked_r;
        take_s       = 1'b0;
        take_idx_s   = NO_OWNER;

        case (state_r)
            IDLE: begin
                grant_s     = 3'b000;
                owner_s     = NO_OWNER;
                locked_s    = 1'b0;
                disp_data_s = DEFAULT_DATA;
                cnt_s       = 32'd0;
                if (idle_pick_s != NO_OWNER) begin
                    take_s     = 1'b1;
                    take_idx_s = idle_pick_s;
                end else begin
                    take_s     = 1'b0;
                end
            end
            HOLD: begin
                // Requests are ignored until the hold period expires.
                disp_data_s = sel_data(owner_r, data0, data1, data2);
                if (cnt_r >= HOLD_CYCLES) begin
                    state_s  = OWN;
                    locked_s = 1'b0;
                end else begin
                    cnt_s    = cnt_r + 32'd1;
                end
            end
            OWN: begin
                // Pre-emption by another requester wins over release.
                if (preempt_pick_s != NO_OWNER) begin
                    take_s     = 1'b1;
                    take_idx_s = preempt_pick_s;
                end else if ((req & grant_r) != 3'b000) begin
                    disp_data_s = sel_data(owner_r, data0, data1, data2);
                end else begin
                    state_s     = IDLE;
                    grant_s     = 3'b000;
                    owner_s     = NO_OWNER;
                    locked_s    = 1'b0;
                    disp_data_s = DEFAULT_DATA;
                    cnt_s       = 32'd0;
                end
            end
            default: begin
                state_s     = IDLE;
                grant_s     = 3'b000;
                owner_s     = NO_OWNER;
                locked_s    = 1'b0;
                disp_data_s = DEFAULT_DATA;
                cnt_s       = 32'd0;
            end
        endcase

        // A new grant starts HOLD; the grant cycle itself is hold cycle 1.
        if (take_s) begin
            state_s      = HOLD;
            cnt_s        = 32'd1;
            last_owner_s = take_idx_s;
            grant_s      = to_onehot(take_idx_s);
            owner_s      = take_idx_s;
            locked_s     = 1'b1;
            disp_data_s  = sel_data(take_idx_s, data0, data1, data2);
        end else begin
            last_owner_s = last_owner_s;
        end
    end

    // State and output registers; reset leaves requester 0 first in line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            cnt_r        <= 32'd0;
            last_owner_r <= 2'd2;
            grant_r      <= 3'b000;
            owner_r      <= NO_OWNER;
            disp_data_r  <= DEFAULT_DATA;
            locked_r     <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            last_owner_r <= last_owner_s;
            grant_r      <= grant_s;
            owner_r      <= owner_s;
            disp_data_r  <= disp_data_s;
            locked_r     <= locked_s;
        end
    end

    assign grant     = grant_r;
    assign owner     = owner_r;
    assign disp_data = disp_data_r;
    assign locked    = locked_r;

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed bench for disp_arbiter with HOLD_CYCLES = 4.
// Inputs change 1 time unit after a rising edge, and outputs are checked at that point too.
module tb_disp_arbiter;

    logic        clk;
    logic        reset_n;
    logic [2:0]  req;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [2:0]  grant;
    logic [1:0]  owner;
    logic [31:0] disp_data;
    logic        locked;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] D0 = 32'h1234_5678;
    localparam logic [31:0] D1 = 32'hcafe_babe;
    localparam logic [31:0] D2 = 32'h9abc_def0;
    localparam logic [31:0] DZ = 32'h0000_0000;

    disp_arbiter #(
        .HOLD_CYCLES (32'd4),
        .DEFAULT_DATA(32'h0000_0000)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .data0    (data0),
        .data1    (data1),
        .data2    (data2),
        .grant    (grant),
        .owner    (owner),
        .disp_data(disp_data),
        .locked   (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] g, input logic [1:0] o,
                           input logic [31:0] d, input logic l);
        chk({tag, ".grant"}, {29'd0, grant}, {29'd0, g});
        chk({tag, ".owner"}, {30'd0, owner}, {30'd0, o});
        chk({tag, ".disp"},  disp_data, d);
        chk({tag, ".locked"}, {31'd0, locked}, {31'd0, l});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] oh(input int i);
        logic [2:0] v;
        v = 3'b000;
        v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [31:0] dsel [3];
        int seq [4];
        dsel[0] = D0; dsel[1] = D1; dsel[2] = D2;
        seq[0] = 0; seq[1] = 1; seq[2] = 2; seq[3] = 0;

        reset_n = 1'b1;
        req     = 3'b000;
        data0   = D0;
        data1   = D1;
        data2   = D2;
        #1 reset_n = 1'b0;
        #2;
        chk_out("reset", 3'b000, 2'd3, DZ, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk_out("idle", 3'b000, 2'd3, DZ, 1'b0);

        // Single requester: grant, 4 locked cycles, OWN, release.
        req = 3'b001;
        tick();
        chk_out("r0_grant", 3'b001, 2'd0, D0, 1'b1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk_out($sformatf("r0_hold%0d", i), 3'b001, 2'd0, D0, 1'b1);
        end
        tick();
        chk_out("r0_own", 3'b001, 2'd0, D0, 1'b0);
        req = 3'b000;
        tick();
        chk_out("r0_release", 3'b000, 2'd3, DZ, 1'b0);

        // A reset pulse restores requester 0 as first in line.
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        tick();

        // All three requesting: 0 -> 1 -> 2 -> 0, each 4 locked cycles and 1 OWN cycle.
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_out($sformatf("rr%0d_grant", k), oh(seq[k]), 2'(seq[k]), dsel[seq[k]], 1'b1);
            if (k < 3) begin
                for (int i = 2; i <= 4; i++) begin
                    tick();
                    chk({$sformatf("rr%0d_hold%0d", k, i), ".locked"}, {31'd0, locked}, 32'd1);
                end
                tick();
                chk_out($sformatf("rr%0d_own", k), oh(seq[k]), 2'(seq[k]), dsel[seq[k]], 1'b0);
            end
        end
        req = 3'b000;
        for (int i = 0; i < 4; i++) tick();
        chk_out("rr_own_last", 3'b001, 2'd0, D0, 1'b0);
        tick();
        chk_out("rr_release", 3'b000, 2'd3, DZ, 1'b0);

        // Owner 1 holding; req2 rises at hold cycle 2 and must wait for the hold to end.
        req = 3'b010;
        tick();
        chk_out("h1_grant", 3'b010, 2'd1, D1, 1'b1);
        tick();
        req = 3'b110;
        tick();
        chk_out("h1_hold3", 3'b010, 2'd1, D1, 1'b1);
        tick();
        chk_out("h1_hold4", 3'b010, 2'd1, D1, 1'b1);
        tick();
        chk_out("h1_own", 3'b010, 2'd1, D1, 1'b0);
        tick();
        chk_out("h2_preempt", 3'b100, 2'd2, D2, 1'b1);

        // Owner 2 drops its request in hold cycle 1; the display follows data2 until release.
        req   = 3'b000;
        data2 = 32'h0bad_f00d;
        tick();
        chk_out("drop_hold2", 3'b100, 2'd2, 32'h0bad_f00d, 1'b1);
        tick();
        tick();
        chk_out("drop_hold4", 3'b100, 2'd2, 32'h0bad_f00d, 1'b1);
        tick();
        chk_out("drop_own", 3'b100, 2'd2, 32'h0bad_f00d, 1'b0);
        tick();
        chk_out("drop_idle", 3'b000, 2'd3, DZ, 1'b0);

        // Asynchronous reset in the middle of owner 1's hold.
        req = 3'b010;
        tick();
        chk_out("ar_grant", 3'b010, 2'd1, D1, 1'b1);
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk_out("ar_async", 3'b000, 2'd3, DZ, 1'b0);
        tick();
        reset_n = 1'b1;
        req     = 3'b011;
        tick();
        chk_out("ar_after", 3'b001, 2'd0, D0, 1'b1);

        // In OWN, owner 0 releasing while requester 1 asks: pre-emption wins.
        req = 3'b010;
        for (int i = 0; i < 4; i++) tick();
        chk_out("pr_own", 3'b001, 2'd0, D0, 1'b0);
        tick();
        chk_out("pr_preempt", 3'b010, 2'd1, D1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 50_000_000, minimum granted display time in clk cycles (legal range 2 to 2^32-1).
REQ-002 SHALL have parameter DEFAULT_DATA, default 32'h00000000, display word shown when no requester owns the display.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req  input  3  per-requester display request, level, bit i = requester i.
REQ-006 SHALL have port data0  input  32  requester 0 display word (8 hex digits, digit 7 in [31:28]).
REQ-007 SHALL have port data1  input  32  requester 1 display word.
REQ-008 SHALL have port data2  input  32  requester 2 display word.
REQ-009 SHALL have port grant  output  3  one-hot ownership, registered; 3'b000 when idle.
REQ-010 SHALL have port owner  output  2  index of current owner, 2'd3 when idle.
REQ-011 SHALL have port disp_data  output  32  registered word to the scan/hc595 display chain.
REQ-012 SHALL have port locked  output  1  high while the hold period is running.

Function
REQ-013 SHALL implement states IDLE, HOLD, OWN.
REQ-014 IDLE: disp_data = DEFAULT_DATA, grant = 0, owner = 3, locked = 0.
REQ-015 IDLE with any req bit high at edge t: SHALL select winner by round-robin, go to HOLD; from edge t, grant/owner indicate winner and locked = 1.
REQ-016 Round-robin: search order starts at (last_owner+1) mod 3, wraps; last_owner resets to 2, so requester 0 has highest priority after reset.
REQ-017 While HOLD or OWN, disp_data SHALL be loaded every cycle from the owner's dataN (one-cycle latency from input to output).
REQ-018 HOLD SHALL last exactly HOLD_CYCLES cycles, counting the grant cycle as cycle 1; req changes (including the owner dropping req) are ignored during HOLD.
REQ-019 After the final HOLD cycle the block SHALL enter OWN with locked = 0.
REQ-020 OWN: if any non-owner req bit is high, SHALL arbitrate among non-owners only (round-robin from owner+1) and enter HOLD with the new owner at the next edge; grant changes in one cycle with no idle gap.
REQ-021 OWN, no other request, owner req high: SHALL remain in OWN indefinitely.
REQ-022 OWN, no other request, owner req low: SHALL return to IDLE at the next edge; disp_data = DEFAULT_DATA from that edge.
REQ-023 Pre-emption (REQ-020) SHALL take precedence over release (REQ-022) on the same cycle.
REQ-024 grant SHALL be one-hot or zero at all times; owner SHALL always match grant.
REQ-025 Hold counter SHALL be 32 bits, cleared on every entry into HOLD, with no wrap inside HOLD.
REQ-026 last_owner SHALL update on every grant.

Reset
REQ-027 reset_n low SHALL force, asynchronously: state IDLE, grant 0, owner 3, locked 0, disp_data DEFAULT_DATA, counter 0, last_owner 2.
REQ-028 Reset asserted mid-HOLD or mid-OWN SHALL abandon ownership immediately; after release, the first request is arbitrated from IDLE per REQ-016.

Verification (bench uses HOLD_CYCLES=4, DEFAULT_DATA=32'h00000000)
REQ-029 Reset, req=000 -> grant 000, owner 3, disp_data 32'h00000000, locked 0.
REQ-030 req=001, data0=32'h12345678 -> next edge grant 001, disp_data 32'h12345678, locked 1 for 4 cycles, then OWN; req0 dropped -> IDLE, disp_data 0.
REQ-031 From IDLE, req=111 on the same cycle -> grant 001; with all requests held, ownership sequence is 001 -> 010 -> 100 -> 001, each owner locked exactly 4 cycles plus 1 OWN cycle.
REQ-032 Owner 1 holding, req2 rises at HOLD cycle 2 -> no change until HOLD ends; next OWN cycle -> grant 100, disp_data = data2 (32'h9abcdef0).
REQ-033 Owner drops req at HOLD cycle 1 -> display stays on owner's data for all 4 cycles, then OWN, then IDLE next edge.
REQ-034 reset_n pulsed low during HOLD of owner 1 -> outputs reset immediately (asynchronous); after release, req=011 -> grant 001.
